// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: iterative signed 32-bit multiply (shift-and-add) / divide (restoring) sequencer.
// Build macro MULTDIV_EARLY_TERM_EN lets a multiply finish as soon as the multiplier is exhausted.
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? -v : v;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               op_div_r;
    logic               sign_r;
    logic               fast_r;
    logic               busy_r;
    logic [WIDTH-1:0]   result_r;
    logic               rdy_r;
    logic               exc_r;
`ifdef MULTDIV_EARLY_TERM_EN
    logic [WIDTH-1:0]   mrem_r;
`endif

    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               start_s;
    logic               fast_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mag_s;
    logic [WIDTH-1:0]   res_s;
    logic               exc_s;

    // Start decode: operand magnitudes and the ops that skip the iteration phase
    always_comb begin
        a_mag_s = magnitude(operand_a);
        b_mag_s = magnitude(operand_b);
        start_s = ctrl_mult | ctrl_div;
        fast_s  = (ctrl_mult & ctrl_div) | (ctrl_div & (operand_b == '0));
    end

    // One iteration: hi half is partial product / remainder, lo half is multiplier / quotient
    always_comb begin
        sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        rem_s  = acc_r[2*WIDTH-2:WIDTH-1];
        step_s = acc_r;
        if (op_div_r) begin
            if (rem_s >= opnd_r) begin
                step_s = {rem_s - opnd_r, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {rem_s, acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
            end else begin
                sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
            end
            step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Final sign correction and exception classification
    always_comb begin
`ifdef MULTDIV_EARLY_TERM_EN
        // an early exit leaves the product short of its final right shifts
        prod_s = acc_r >> (LAST_CNT - cnt_r);
`else
        prod_s = acc_r;
`endif
        mag_s = '0;
        res_s = '0;
        exc_s = 1'b0;
        if (fast_r) begin
            exc_s = 1'b1;
        end else if (op_div_r) begin
            mag_s = acc_r[WIDTH-1:0];
            res_s = sign_r ? -mag_s : mag_s;
            exc_s = ~sign_r & mag_s[WIDTH-1];
        end else begin
            mag_s = prod_s[WIDTH-1:0];
            res_s = sign_r ? -mag_s : mag_s;
            if (sign_r) begin
                exc_s = (|prod_s[2*WIDTH-1:WIDTH]) | (mag_s[WIDTH-1] & (|mag_s[WIDTH-2:0]));
            end else begin
                exc_s = |prod_s[2*WIDTH-1:WIDTH-1];
            end
        end
    end

    // Sequencer FSM with datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            opnd_r   <= '0;
            op_div_r <= 1'b0;
            sign_r   <= 1'b0;
            fast_r   <= 1'b0;
            busy_r   <= 1'b0;
            result_r <= '0;
            rdy_r    <= 1'b0;
            exc_r    <= 1'b0;
`ifdef MULTDIV_EARLY_TERM_EN
            mrem_r   <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (busy_r) begin
                        busy_r <= 1'b0;
                        rdy_r  <= 1'b0;
                        exc_r  <= 1'b0;
                    end else if (start_s) begin
                        busy_r   <= 1'b1;
                        op_div_r <= ctrl_div;
                        fast_r   <= fast_s;
                        sign_r   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        opnd_r   <= ctrl_div ? b_mag_s : a_mag_s;
                        acc_r    <= {{WIDTH{1'b0}}, (ctrl_div ? a_mag_s : b_mag_s)};
                        cnt_r    <= '0;
`ifdef MULTDIV_EARLY_TERM_EN
                        mrem_r   <= b_mag_s;
`endif
                        state_r  <= fast_s ? DONE : RUN;
                    end else begin
                        rdy_r <= 1'b0;
                        exc_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= step_s;
`ifdef MULTDIV_EARLY_TERM_EN
                    mrem_r <= {1'b0, mrem_r[WIDTH-1:1]};
                    if ((cnt_r == LAST_CNT) || (!op_div_r && (mrem_r[WIDTH-1:1] == '0))) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
`else
                    if (cnt_r == LAST_CNT) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
`endif
                end
                DONE: begin
                    result_r <= res_s;
                    exc_r    <= exc_s;
                    rdy_r    <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign result     = result_r;
    assign result_rdy = rdy_r;
    assign exception  = exc_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes model expectations, a negedge monitor checks strobes.
`timescale 1ns/1ps
module tb_multdiv_ctrl;
    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ctrl_mult = 1'b0;
    logic             ctrl_div = 1'b0;
    logic [WIDTH-1:0] operand_a = '0;
    logic [WIDTH-1:0] operand_b = '0;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_rdy;
    logic             exception;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             exc;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   mid_cycle = -1;
    int   post_cycle = -1;
    int   zero_cycle = -1;

    multdiv_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .result     (result),
        .result_rdy (result_rdy),
        .exception  (exception)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: pops expectations on every strobe, flags missing/extra strobes and idle state
    always @(negedge clock) begin : monitor
        exp_t e;
        if (result_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: cycle %0d result %h exc %b, no op outstanding",
                         cyc, result, exception);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("exception", 32'(exception), 32'(e.exc));
                check("strobe_cycle", cyc, e.cyc);
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL no_strobe: cycle %0d, strobe expected at cycle %0d", cyc, e.cyc);
        end
        if (cyc == mid_cycle) begin
            check("busy_in_flight", 32'(busy), 32'd1);
        end
        if (cyc == post_cycle) begin
            check("busy_after", 32'(busy), 32'd0);
            check("rdy_after", 32'(result_rdy), 32'd0);
        end
        if (cyc == zero_cycle) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_result", result, 32'd0);
            check("rst_rdy", 32'(result_rdy), 32'd0);
            check("rst_exc", 32'(exception), 32'd0);
        end
    end

    // Reference model from signed arithmetic on 64-bit integers
    function automatic void model(input logic m, input logic d,
                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] r, output logic x, output int lat);
        longint sa;
        longint sbv;
        longint p;
`ifdef MULTDIV_EARLY_TERM_EN
        longint unsigned mb;
        int hb;
`endif
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = WIDTH + 1;
        r   = '0;
        x   = 1'b0;
        if (m && d) begin
            x   = 1'b1;
            lat = 1;
        end else if (m) begin
            p = sa * sbv;
            r = p[31:0];
            x = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef MULTDIV_EARLY_TERM_EN
            mb = (sbv < 0) ? longint'(-sbv) : sbv;
            if (mb == 0) begin
                lat = 2;
            end else begin
                hb = 0;
                for (int i = 0; i < WIDTH; i++) if (mb[i]) hb = i;
                lat = hb + 2;
            end
`endif
        end else if (b == '0) begin
            x   = 1'b1;
            lat = 1;
        end else begin
            p = sa / sbv;
            r = p[31:0];
            x = p > 64'sd2147483647;
        end
    endfunction

    function automatic logic [WIDTH-1:0] rand_opnd();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 300);
            2: begin
                v = $urandom_range(0, 300);
                v = -v;
            end
            default: begin
                case ($urandom_range(0, 4))
                    0: v = 32'h8000_0000;
                    1: v = 32'h7FFF_FFFF;
                    2: v = 32'hFFFF_FFFF;
                    3: v = 32'h0000_0000;
                    default: v = 32'h0000_0001;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic issue(input logic m, input logic d,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int inj, input logic [1:0] inj_md);
        exp_t e;
        int   lat;
        int   e0;
        model(m, d, a, b, e.res, e.exc, lat);
        @(negedge clock);
        ctrl_mult = m;
        ctrl_div  = d;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        e0 = cyc;
        e.cyc = e0 + lat;
        sb.push_back(e);
        mid_cycle  = e0;
        post_cycle = e0 + lat + 1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        for (int k = 0; k < lat + 4; k++) begin
            @(negedge clock);
            if (inj > 0 && inj <= lat + 1 && cyc == e0 + inj - 1) begin
                ctrl_mult = inj_md[1];
                ctrl_div  = inj_md[0];
                operand_a = $urandom;
                operand_b = $urandom;
            end else begin
                ctrl_mult = 1'b0;
                ctrl_div  = 1'b0;
            end
        end
    endtask

    task automatic reset_mid_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int e0;
        @(negedge clock);
        ctrl_mult = 1'b1;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        e0 = cyc;
        mid_cycle = e0;
        ctrl_mult = 1'b0;
        for (int k = 0; k < 60 && cyc < e0 + 19; k++) @(negedge clock);
        reset = 1'b0;
        zero_cycle = e0 + 20;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
    endtask

    initial begin
        int sel;
        int inj;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset = 1'b0;
        zero_cycle = 2;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 0, 2'b00);
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 2'b00);
        issue(1'b1, 1'b0, 32'h4000_0000, 32'hFFFF_FFFE, 0, 2'b00);
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 2'b00);
        issue(1'b0, 1'b1, 32'd5, 32'd0, 0, 2'b00);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00);
        issue(1'b1, 1'b1, 32'd11, 32'd13, 0, 2'b00);
        issue(1'b1, 1'b0, 32'd3, 32'd4, 10, 2'b01);
        issue(1'b1, 1'b0, 32'd9, 32'd2, 0, 2'b00);
        issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 0, 2'b00);
        issue(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 2'b00);
        reset_mid_op(32'h1234_5678, 32'h8000_0001);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra  = rand_opnd();
            rb  = rand_opnd();
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 34)) : 0;
            if (sel == 0) begin
                issue(1'b1, 1'b1, ra, rb, inj, 2'($urandom_range(1, 3)));
            end else if (sel < 5) begin
                issue(1'b1, 1'b0, ra, rb, inj, 2'($urandom_range(1, 3)));
            end else begin
                issue(1'b0, 1'b1, ra, rb, inj, 2'($urandom_range(1, 3)));
            end
        end

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
